// File: rtl/csa_accumulator.sv
// Frame accumulator: carry-save 3:2 compression per operand, then a two-cycle
// split carry-propagate resolve (low half, high half) before presenting the sum.
module csa_accumulator #(
    parameter int WIDTH = 16,
    parameter int GUARD = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH+GUARD-1:0] out_sum,
    output logic                   out_ovf,
    output logic [2:0]             o_dbg_state
);

    localparam int AW = WIDTH + GUARD;
    localparam int LO = AW / 2;
    localparam int HI = AW - LO;
    localparam int CW = GUARD + 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(1 << GUARD);
    localparam logic [CW-1:0] CNT_SAT = CW'((1 << GUARD) + 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    typedef enum logic [2:0] {IDLE, ACCUM, RES_LO, RES_HI, OUT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_s;
    logic [AW-1:0]   r_c;
    logic [CW-1:0]   r_cnt;
    logic [LO-1:0]   r_lo;
    logic            r_lo_cy;
    logic [AW-1:0]   r_sum;
    logic            r_ovf;

    logic            w_xfer;
    logic [AW-1:0]   w_x;
    logic [AW-2:0]   w_maj;
    logic [LO:0]     w_lo_add;
    logic [HI-1:0]   w_hi_add;

    assign w_x      = {{GUARD{1'b0}}, in_data};
    assign w_xfer   = in_valid & in_ready;
    // Only the low AW-1 majority bits survive the left shift into the carry vector.
    assign w_maj    = (r_s[AW-2:0] & r_c[AW-2:0]) | (r_s[AW-2:0] & w_x[AW-2:0]) |
                      (r_c[AW-2:0] & w_x[AW-2:0]);
    assign w_lo_add = {1'b0, r_s[LO-1:0]} + {1'b0, r_c[LO-1:0]};
    assign w_hi_add = r_s[AW-1:LO] + r_c[AW-1:LO] + {{(HI-1){1'b0}}, r_lo_cy};

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_xfer) w_next = in_last ? RES_LO : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (w_xfer && in_last) w_next = RES_LO;
            end
            RES_LO: w_next = RES_HI;
            RES_HI: w_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_c     <= '0;
            r_cnt   <= '0;
            r_lo    <= '0;
            r_lo_cy <= 1'b0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_xfer) begin
                    r_s   <= w_x;
                    r_c   <= '0;
                    r_cnt <= CW'(1);
                end
                ACCUM: if (w_xfer) begin
                    r_s   <= r_s ^ r_c ^ w_x;
                    r_c   <= {w_maj, 1'b0};
                    r_cnt <= (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);
                end
                RES_LO: begin
                    r_lo    <= w_lo_add[LO-1:0];
                    r_lo_cy <= w_lo_add[LO];
                end
                RES_HI: begin
                    r_sum <= {w_hi_add, r_lo};
                    r_ovf <= (r_cnt > CNT_LIM);
                end
                default: ;
            endcase
        end
    end

    assign out_sum     = r_sum;
    assign out_ovf     = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits (minimum 2).
REQ-002 SHALL have parameter GUARD, default 4, giving the guard bits; AW = WIDTH+GUARD is the accumulator/result width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, operand valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-007 SHALL have port in_data, input, WIDTH, unsigned operand.
REQ-008 SHALL have port in_last, input, 1, marks the final operand of a frame; qualified by in_valid.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port out_sum, output, AW, frame sum modulo 2^AW.
REQ-012 SHALL have port out_ovf, output, 1, frame held more than 2^GUARD operands.

Function
REQ-013 SHALL implement states IDLE, ACCUM, RES_LO, RES_HI, OUT.
REQ-014 SHALL transfer an operand on a rising edge where in_valid and in_ready are both 1.
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in RES_LO, RES_HI and OUT.
REQ-016 SHALL hold redundant state S, C (each AW bits); an IDLE transfer loads S=zext(in_data), C=0.
REQ-017 SHALL, on an ACCUM transfer, apply 3:2 compression: S'=S^C^X; C'=(maj(S,C,X)<<1) truncated to AW; X=zext(in_data).
REQ-018 SHALL leave S and C unchanged on cycles with no transfer; in_valid=0 gaps are legal.
REQ-019 SHALL make these transitions: IDLE->ACCUM on transfer with in_last=0; IDLE->RES_LO on transfer with in_last=1; ACCUM->RES_LO on transfer with in_last=1; otherwise remain.
REQ-020 SHALL, in RES_LO, add the low floor(AW/2) bits of S and C, register the partial sum and its carry-out, then go to RES_HI.
REQ-021 SHALL, in RES_HI, add the high bits of S and C plus the registered carry, form out_sum (final carry-out discarded), then go to OUT.
REQ-022 SHALL give a latency of 3 cycles: a last operand transferred at edge N gives out_valid=1 from the cycle after edge N+2.
REQ-023 SHALL assert out_valid only in OUT, with out_sum and out_ovf stable until the handshake.
REQ-024 SHALL go OUT->IDLE on out_valid and out_ready; in_ready rises the following cycle with no same-cycle bypass.
REQ-025 SHALL count operands per frame in a GUARD+1-bit counter saturating at 2^GUARD+1, with out_ovf=1 if count>2^GUARD.
REQ-026 SHALL clear the counter at the start of each frame; counter and out_ovf do not affect the out_sum arithmetic.
REQ-027 SHALL ignore out_ready outside OUT and ignore in_data and in_last when in_ready=0.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE, S=C=0, counter=0, out_sum=0, out_ovf=0, out_valid=0.
REQ-029 SHALL drive in_ready=1 after release of reset.
REQ-030 SHALL make reset in any state, including mid-frame or OUT, discard the frame; no partial result is ever presented.

Verification (WIDTH=16, GUARD=4)
REQ-031 SHALL cover: operands 100, 200, 300 (last on 300) back-to-back -> out_sum=600, out_ovf=0, out_valid 3 cycles after the last transfer.
REQ-032 SHALL cover: 16 operands of 0xFFFF -> out_sum=0xFFFF0, out_ovf=0; the same with 17 operands -> out_sum=0x0FFEF, out_ovf=1.
REQ-033 SHALL cover: a single operand 0x1234 with in_last=1 from IDLE -> out_sum=0x01234 via IDLE->RES_LO.
REQ-034 SHALL cover: out_ready=0 for 5 cycles in OUT -> out_valid, out_sum and out_ovf held and in_ready=0; after the handshake, in_ready=1 the next cycle.
REQ-035 SHALL cover: random in_valid gaps over 1000 random frames -> out_sum equals the reference sum mod 2^20 and out_ovf matches the count rule.
REQ-036 SHALL cover: rst_n low for 1 cycle after 3 operands -> all outputs at reset values; a next frame 5, 7 -> out_sum=12.
